// File: rtl/divider_defs.sv
// divider_defs: shared widths and FSM encoding for the sequential divider
package divider_defs;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W = 4;
  localparam int CNT_W = $clog2(DIVIDEND_W);
  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;
endpackage

// File: rtl/full_adder_mux.sv
// full_adder_mux: one-bit full adder whose carry is a propagate-selected mux
module full_adder_mux (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p;
  assign p = a ^ b;
  assign sum = p ^ cin;
  assign cout = p ? cin : a;
endmodule

// File: rtl/ripple_subtractor.sv
// ripple_subtractor: a - b as a + ~b + 1; carry-out high means no borrow
module ripple_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);
  logic [W:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder_mux u_fa (.a(a[i]), .b(~b[i]), .cin(c[i]), .sum(diff[i]), .cout(c[i+1]));
  end
  assign no_borrow = c[W];
endmodule

// File: rtl/seq_divider_8x4.sv
// seq_divider_8x4: restoring divider resolving one quotient bit per clock
module seq_divider_8x4
  import divider_defs::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  state_t state, state_n;
  logic [DIVIDEND_W-1:0] q, q_n, quotient_n;
  logic [DIVISOR_W:0] r, r_n, r_shift, diff;
  logic [DIVISOR_W-1:0] d, d_n, remainder_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic no_borrow, busy_n, done_n, dbz_n;
  logic r_msb_unused;
  assign r_shift = {r[DIVISOR_W-1:0], q[DIVIDEND_W-1]};
  assign r_msb_unused = r[DIVISOR_W];
  ripple_subtractor #(.W(DIVISOR_W + 1)) u_sub (
    .a(r_shift),
    .b({1'b0, d}),
    .diff(diff),
    .no_borrow(no_borrow)
  );
  // next state, datapath iteration and result capture
  always_comb begin
    state_n = state;
    q_n = q;
    r_n = r;
    d_n = d;
    cnt_n = cnt;
    busy_n = busy;
    done_n = 1'b0;
    dbz_n = div_by_zero;
    quotient_n = quotient;
    remainder_n = remainder;
    if (state == IDLE && start && divisor == '0) begin
      done_n = 1'b1;
      dbz_n = 1'b1;
      quotient_n = '1;
      remainder_n = '0;
    end else if (state == IDLE && start) begin
      q_n = dividend;
      d_n = divisor;
      r_n = '0;
      cnt_n = CNT_W'(DIVIDEND_W - 1);
      dbz_n = 1'b0;
      busy_n = 1'b1;
      state_n = CALC;
    end else if (state == CALC) begin
      q_n = {q[DIVIDEND_W-2:0], no_borrow};
      r_n = no_borrow ? diff : r_shift;
      cnt_n = cnt - 1'b1;
      if (cnt == '0) begin
        quotient_n = q_n;
        remainder_n = r_n[DIVISOR_W-1:0];
        done_n = 1'b1;
        busy_n = 1'b0;
        state_n = IDLE;
      end
    end
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      quotient <= '0;
      remainder <= '0;
    end else begin
      state <= state_n;
      q <= q_n;
      r <= r_n;
      d <= d_n;
      cnt <= cnt_n;
      busy <= busy_n;
      done <= done_n;
      div_by_zero <= dbz_n;
      quotient <= quotient_n;
      remainder <= remainder_n;
    end
  end
endmodule

// File: tb/tb_seq_divider_8x4.sv
// tb_seq_divider_8x4: directed and exhaustive checks against a cycle-level reference model
module tb_seq_divider_8x4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int m_left = 0;
  logic m_busy, m_done, m_z;
  logic [7:0] m_q, pq;
  logic [3:0] m_r, pr;

  always #5 clk = ~clk;

  seq_divider_8x4 dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: an accepted divide takes 8 edges, divide-by-zero answers at once
  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_z <= 1'b0;
      m_q <= '0;
      m_r <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_q <= pq;
          m_r <= pr;
        end
      end else if (start && divisor == 4'd0) begin
        m_done <= 1'b1;
        m_z <= 1'b1;
        m_q <= 8'hFF;
        m_r <= 4'd0;
      end else if (start) begin
        m_left <= 8;
        m_busy <= 1'b1;
        m_z <= 1'b0;
        pq <= dividend / {4'd0, divisor};
        pr <= 4'(dividend % {4'd0, divisor});
      end
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 16'(busy), 16'(m_busy));
      chk("done", 16'(done), 16'(m_done));
      chk("div_by_zero", 16'(div_by_zero), 16'(m_z));
      chk("quotient_hold", 16'(quotient), 16'(m_q));
      chk("remainder_hold", 16'(remainder), 16'(m_r));
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                       input logic [3:0] er, input bit ez, input bit hold, input bit pin);
    int i;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    i = 1;
    if (!hold) start = 1'b0;
    while (!done && i < 30) begin
      if (hold) begin
        dividend = 8'($urandom);
        divisor = 4'($urandom);
      end
      @(negedge clk);
      i++;
    end
    start = 1'b0;
    chk("latency", 16'(i), (b == 4'd0) ? 16'd1 : 16'd9);
    chk("quotient", 16'(quotient), 16'(eq));
    chk("remainder", 16'(remainder), 16'(er));
    chk("dbz", 16'(div_by_zero), 16'(ez));
    if (pin) begin
      chk("model_q", 16'(m_q), 16'(eq));
      chk("model_r", 16'(m_r), 16'(er));
    end
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_q", 16'(quotient), 16'd0);
    chk("rst_r", 16'(remainder), 16'd0);
    do_op(8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 1'b0, 1'b1);
    do_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b0, 1'b1);
    do_op(8'd200, 4'd15, 8'd13, 4'd5, 1'b0, 1'b0, 1'b1);
    do_op(8'd7, 4'd9, 8'd0, 4'd7, 1'b0, 1'b0, 1'b1);
    do_op(8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    do_op(8'd77, 4'd0, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b1);
    do_op(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b0, 1'b1);
    do_op(8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 1'b1, 1'b1);
    do_op(8'd60, 4'd4, 8'd15, 4'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    dividend = 8'd255;
    divisor = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_q", 16'(quotient), 16'd0);
    chk("abort_r", 16'(remainder), 16'd0);
    chk("abort_dbz", 16'(div_by_zero), 16'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 16'(seen), 16'd0);
    do_op(8'd255, 4'd3, 8'd85, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        do_op(8'(a), 4'(b), (b == 0) ? 8'hFF : 8'(a / b), (b == 0) ? 4'd0 : 4'(a % b),
              b == 0, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        do_op(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
